// File: rtl/new_mem_if.sv
// new_mem_if: enable/address/data bus between a requester and the new_mem scratch store
interface new_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  enable;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] Data_in;
  logic [DATA_WIDTH-1:0] Data_out;
  modport master (output enable, output addr, output Data_in, input Data_out);
  modport slave  (input enable, input addr, input Data_in, output Data_out);
endinterface

// File: rtl/new_mem.sv
// new_mem: 16x32 single-port register file, enable=1 writes, enable=0 reads with a registered output
module new_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  new_mem_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  always_comb begin
    mem_d = mem_q;
    if (bus.enable) mem_d[bus.addr] = bus.Data_in;
    // write cycles hold the last read value; no write-through
    data_out_d = bus.enable ? data_out_q : mem_q[bus.addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end
  assign bus.Data_out = data_out_q;
endmodule

// File: tb/tb_new_mem.sv
// tb_new_mem: directed scenarios plus randomized traffic against a plain array model of the store
module tb_new_mem;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] ref_out;

  new_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
  new_mem dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic en, input logic [3:0] a, input logic [31:0] d);
    rst = r;
    bus.enable = en;
    bus.addr = a;
    bus.Data_in = d;
    @(posedge clk);
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_out = '0;
    end else if (en) ref_mem[a] = d;
    else ref_out = ref_mem[a];
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 9, 32'hFFFF_FFFF);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=%h", bus.Data_out, 32'h0);
    end
    cyc(0, 0, 5, 0);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_read5 got=%h exp=%h", bus.Data_out, 32'h0);
    end
  endtask

  task automatic test_write_read;
    cyc(0, 1, 3, 32'h1234_5678);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL write_no_through got=%h exp=%h", bus.Data_out, 32'h0);
    end
    cyc(0, 0, 3, 0);
    total++;
    if (bus.Data_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL read_back3 got=%h exp=%h", bus.Data_out, 32'h1234_5678);
    end
  endtask

  task automatic test_isolation;
    logic [3:0]  a [3] = '{4'd5, 4'd0, 4'd3};
    logic [31:0] e [3] = '{32'h0, 32'hAABB_CCDD, 32'h1234_5678};
    cyc(0, 1, 0, 32'hAABB_CCDD);
    cyc(0, 1, 3, 32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, a[k], 0);
      total++;
      if (bus.Data_out !== e[k]) begin
        bad++;
        $display("FAIL isolation addr=%0d got=%h exp=%h", a[k], bus.Data_out, e[k]);
      end
    end
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 4'(i), 0);
      total++;
      if (bus.Data_out !== 32'hA5A5_0000 + 32'(i)) begin
        bad++;
        $display("FAIL sweep addr=%0d got=%h exp=%h", i, bus.Data_out, 32'hA5A5_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_overwrite_hold;
    cyc(0, 1, 7, 32'h1111_1111);
    cyc(0, 1, 7, 32'h2222_2222);
    cyc(0, 0, 7, 0);
    total++;
    if (bus.Data_out !== 32'h2222_2222) begin
      bad++;
      $display("FAIL overwrite got=%h exp=%h", bus.Data_out, 32'h2222_2222);
    end
    cyc(0, 1, 2, 32'h3333_3333);
    total++;
    if (bus.Data_out !== 32'h2222_2222) begin
      bad++;
      $display("FAIL hold_on_write got=%h exp=%h", bus.Data_out, 32'h2222_2222);
    end
  endtask

  task automatic test_reset_priority;
    cyc(1, 1, 3, 32'hDEAD_BEEF);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_prio_out got=%h exp=%h", bus.Data_out, 32'h0);
    end
    cyc(0, 0, 3, 0);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_prio_read3 got=%h exp=%h", bus.Data_out, 32'h0);
    end
    cyc(0, 0, 7, 0);
    total++;
    if (bus.Data_out !== 32'h0) begin
      bad++;
      $display("FAIL rst_clears7 got=%h exp=%h", bus.Data_out, 32'h0);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 40) == 0, $urandom % 2 == 1, 4'($urandom), $urandom);
      total++;
      if (bus.Data_out !== ref_out) begin
        bad++;
        $display("FAIL random n=%0d addr=%0d got=%h exp=%h", n, bus.addr, bus.Data_out, ref_out);
      end
    end
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 4'(i), 0);
      total++;
      if (bus.Data_out !== ref_out) begin
        bad++;
        $display("FAIL random_drain addr=%0d got=%h exp=%h", i, bus.Data_out, ref_out);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.addr = '0;
    bus.Data_in = '0;
    ref_out = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_isolation();
    test_sweep();
    test_overwrite_hold();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
